// File: rtl/relay_encode.sv
// -----------------------------------------------------------------------------
// relay_encode
//
// Serial relay encoder. Symbols offered on data_in are decoded to single bits
// and queued in a 4-entry bit FIFO. Each queued bit is then driven on data_out
// for one 64-clock bit period. Consecutive queued bits go out with no gap.
//
// Ports
//   clk        in   sole clock; all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset; clears all state at once
//   mode       in   code select: 1 -> one-code 4'hc, 0 -> one-code 4'hf
//   data_in    in   [3:0] symbol: one-code -> bit 1, 4'h0 -> bit 0,
//                   any other value -> bit 0 and err is raised
//   data_valid in   data_in is offered this cycle
//   ready      out  FIFO has room (count < 4); derived from the registered count
//   data_out   out  serial line; 0 whenever no bit is being sent
//   busy       out  high in any state other than IDLE
//   err        out  sticky illegal-symbol flag; cleared only by reset_n
//
// Build option
//   RELAY_ENCODE_GUARD_EN  when defined, a 64-cycle low GUARD period follows
//                          the last bit of every burst. busy stays high during
//                          GUARD and pushes are still accepted. Without it,
//                          SEND returns straight to IDLE.
// -----------------------------------------------------------------------------
module relay_encode (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mode,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       data_out,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
`ifdef RELAY_ENCODE_GUARD_EN
  localparam logic [1:0] ST_GUARD = 2'd2;
`endif

  localparam logic [5:0] PHASE_LAST = 6'd63;
  localparam logic [2:0] FIFO_DEPTH = 3'd4;

  logic [1:0] state_reg;
  logic [5:0] phase_reg;
  logic [3:0] fifo_reg;
  logic [1:0] rd_ptr_reg;
  logic [1:0] wr_ptr_reg;
  logic [2:0] count_reg;
  logic       data_out_reg;
  logic       err_reg;

  logic [3:0] one_code;
  logic       sym_bit;
  logic       sym_illegal;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic       head_bit;

  // Decoding uses mode as sampled at the accepting edge. Once a bit is in the
  // FIFO it is independent of mode.
  always_comb begin
    one_code    = mode ? 4'hc : 4'hf;
    sym_bit     = (data_in == one_code);
    sym_illegal = !sym_bit && (data_in != 4'h0);
  end

  assign ready      = (count_reg < FIFO_DEPTH);
  assign push       = data_valid && ready;
  assign fifo_empty = (count_reg == 3'd0);
  assign head_bit   = fifo_reg[rd_ptr_reg];

  // Pops happen only when the line is free to take a new bit. That is either
  // from IDLE, or at the last phase of the current bit so the next bit follows
  // with no gap. GUARD never pops. Its exit to IDLE gives the one-cycle hop
  // before SEND.
  assign pop = !fifo_empty &&
               ((state_reg == ST_IDLE) ||
                ((state_reg == ST_SEND) && (phase_reg == PHASE_LAST)));

  // Bit FIFO. When full, push is already blocked by ready, so a pop on the
  // same edge cannot make room for it. A simultaneous push and pop leaves the
  // count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_reg   <= 4'b0000;
      rd_ptr_reg <= 2'd0;
      wr_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (push) begin
        fifo_reg[wr_ptr_reg] <= sym_bit;
        wr_ptr_reg           <= wr_ptr_reg + 2'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else if (push && sym_illegal) begin
      err_reg <= 1'b1;
    end
  end

  // Line state machine. phase counts 0..63 within a bit period. The 6-bit
  // wrap from 63 to 0 starts the next period, or leaves phase at 0 on exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= 6'd0;
      data_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          phase_reg    <= 6'd0;
          data_out_reg <= 1'b0;
          if (!fifo_empty) begin
            state_reg    <= ST_SEND;
            data_out_reg <= head_bit;
          end
        end
        ST_SEND: begin
          phase_reg <= phase_reg + 6'd1;
          if (phase_reg == PHASE_LAST) begin
            if (!fifo_empty) begin
              data_out_reg <= head_bit;
            end else begin
              data_out_reg <= 1'b0;
`ifdef RELAY_ENCODE_GUARD_EN
              state_reg    <= ST_GUARD;
`else
              state_reg    <= ST_IDLE;
`endif
            end
          end
        end
`ifdef RELAY_ENCODE_GUARD_EN
        ST_GUARD: begin
          phase_reg    <= phase_reg + 6'd1;
          data_out_reg <= 1'b0;
          if (phase_reg == PHASE_LAST) begin
            state_reg <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_reg    <= ST_IDLE;
          phase_reg    <= 6'd0;
          data_out_reg <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_out_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign err      = err_reg;

endmodule

// File: tb/tb_relay_encode.sv
// -----------------------------------------------------------------------------
// tb_relay_encode
//
// The reference model is a line schedule. Every accepted symbol is given a
// start edge and occupies the line for 64 cycles after that edge. A bit
// accepted while the previous bit is still on the line starts right where that
// bit ends. Otherwise it starts one edge after acceptance, or after the guard
// window when guard is built in. Line level, busy, FIFO occupancy (hence
// ready) and err are all read off this schedule.
// -----------------------------------------------------------------------------
module tb_relay_encode;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic       data_valid = 1'b0;
  logic       ready;
  logic       data_out;
  logic       busy;
  logic       err;

  relay_encode dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .data_out   (data_out),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

`ifdef RELAY_ENCODE_GUARD_EN
  localparam int GUARD = 64;
`else
  localparam int GUARD = 0;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;          // index of the most recent rising edge
  int   nacc = 0;
  int   last_end = -1000; // edge at which the last scheduled bit leaves the line
  int   last_acc = 0;
  int   acc_edge [64];
  int   st       [64];
  logic acc_bit  [64];
  logic ill      [64];
  logic mb;
  int   ms;
  int   a;
  logic [4:0] s2_pat = 5'b01101;  // bits 1,0,1,1,0 sent in order k=0..4

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // FIFO occupancy just after edge n: accepted, not yet started.
  function automatic int m_count(input int n);
    int c = 0;
    for (int i = 0; i < nacc; i++)
      if (acc_edge[i] <= n && st[i] > n) c++;
    return c;
  endfunction

  function automatic logic m_line(input int n);
    for (int i = 0; i < nacc; i++)
      if (st[i] <= n && n < st[i] + 64) return acc_bit[i];
    return 1'b0;
  endfunction

  function automatic logic m_busy(input int n);
    for (int i = 0; i < nacc; i++)
      if (st[i] <= n && n < st[i] + 64) return 1'b1;
    for (int i = 0; i < nacc; i++) begin
      int  e;
      logic followed;
      e = st[i] + 64;
      followed = 1'b0;
      for (int j = 0; j < nacc; j++)
        if (st[j] == e) followed = 1'b1;
      if (!followed && e <= n && n < e + GUARD) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic m_err();
    for (int i = 0; i < nacc; i++)
      if (ill[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Call at a falling edge. Offers sym until accepted, returns at the falling
  // edge after the accepting rising edge.
  task automatic push(input logic [3:0] sym);
    int g = 0;
    data_in    = sym;
    data_valid = 1'b1;
    while (!ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    last_acc   = cyc;
    data_valid = 1'b0;
    $display("push sym=%h mode=%0d accepted at edge %0d", sym, mode, cyc);
  endtask

  task automatic wait_to(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    wait_to(last_end + GUARD + 2);
  endtask

  initial begin
    fork
      // model update at each rising edge
      forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (!reset_n) begin
          nacc     = 0;
          last_end = -1000;
        end else if (data_valid && m_count(cyc - 1) < 4 && nacc < 64) begin
          mb = (data_in == (mode ? 4'hc : 4'hf));
          if (cyc < last_end) begin
            ms = last_end;
          end else begin
            ms = cyc + 1;
            if (last_end + GUARD + 1 > ms) ms = last_end + GUARD + 1;
          end
          acc_edge[nacc] = cyc;
          acc_bit[nacc]  = mb;
          ill[nacc]      = (data_in != 4'h0) && !mb;
          st[nacc]       = ms;
          nacc           = nacc + 1;
          last_end       = ms + 64;
        end
      end
      // every-cycle compare against the model
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          chk("rst_data_out", data_out, 0);
          chk("rst_busy", busy, 0);
          chk("rst_ready", ready, 1);
          chk("rst_err", err, 0);
        end else begin
          chk("data_out", data_out, m_line(cyc));
          chk("busy", busy, m_busy(cyc));
          chk("ready", ready, m_count(cyc) < 4);
          chk("err", err, m_err());
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_ready_lit", ready, 1);
    chk("reset_out_lit", data_out, 0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Single 1 bit, mode 1
    mode = 1'b1;
    push(4'hc);
    a = last_acc;
    chk("s1_lat_out", data_out, 0);
    chk("s1_lat_busy", busy, 0);
    @(negedge clk);
    chk("s1_first_out", data_out, 1);
    chk("s1_first_busy", busy, 1);
    wait_to(a + 64);
    chk("s1_last_out", data_out, 1);
    wait_to(a + 65);
    chk("s1_after_out", data_out, 0);
    chk("s1_after_busy", busy, GUARD > 0);
    chk("s1_err", err, 0);

    // Back-to-back 1,0,1,1,0, mode 0
    wait_idle();
    mode = 1'b0;
    push(4'hf);
    a = last_acc;
    push(4'h0);
    push(4'hf);
    push(4'hf);
    push(4'h0);
    for (int k = 0; k < 5; k++) begin
      wait_to(a + 1 + 64 * k + 32);
      chk("s2_bit", data_out, s2_pat[k]);
    end
    wait_to(a + 1 + 320);
    chk("s2_end_out", data_out, 0);

    // Fill the FIFO: ready must drop with four bits queued
    wait_idle();
    push(4'hf);
    a = last_acc;
    push(4'h0);
    push(4'hf);
    push(4'h0);
    push(4'hf);
    chk("s3_full_ready", ready, 0);
    push(4'hf);
    chk("s3_sixth_edge", last_acc, a + 66);

    // Boundary: push one edge before the bit ends (contiguous), then exactly
    // at the edge where it ends (one idle cycle first)
    wait_idle();
    mode = 1'b1;
    push(4'hc);
    a = last_acc;
    repeat (63) @(negedge clk);
    push(4'h0);
    chk("s4_still_first", data_out, 1);
    @(negedge clk);
    chk("s4_contig_out", data_out, 0);
    chk("s4_contig_busy", busy, 1);
    wait_to(a + 128);
    push(4'hc);
    chk("s4_gap_out", data_out, 0);
    chk("s4_gap_busy", busy, GUARD > 0);
    @(negedge clk);
    chk("s4_next_out", data_out, GUARD == 0);

    // Illegal symbol, mode change with a bit queued
    wait_idle();
    mode = 1'b1;
    push(4'hf);
    a = last_acc;
    chk("s5_err_set", err, 1);
    push(4'hc);
    mode = 1'b0;
    push(4'hc);
    wait_to(a + 65 + 32);
    chk("s5_mode_change", data_out, 1);
    wait_to(a + 129 + 32);
    chk("s5_c_under_mode0", data_out, 0);
    wait_idle();
    chk("s5_err_sticky", err, 1);

`ifdef RELAY_ENCODE_GUARD_EN
    // Guard period between two single-bit bursts
    wait_idle();
    mode = 1'b1;
    push(4'hc);
    a = last_acc;
    wait_to(a + 80);
    push(4'hc);
    chk("g_guard_out", data_out, 0);
    chk("g_guard_busy", busy, 1);
    wait_to(a + 129);
    chk("g_idle_busy", busy, 0);
    wait_to(a + 130);
    chk("g_second_out", data_out, 1);
`endif

    // Asynchronous reset mid-bit with three bits queued
    wait_idle();
    mode = 1'b1;
    push(4'hc);
    a = last_acc;
    push(4'hc);
    push(4'h0);
    push(4'hc);
    wait_to(a + 31);
    chk("s6_pre_out", data_out, 1);
    chk("s6_pre_err", err, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("s6_async_out", data_out, 0);
    chk("s6_async_busy", busy, 0);
    chk("s6_async_err", err, 0);
    chk("s6_async_ready", ready, 1);
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("s6_no_residual_out", data_out, 0);
    chk("s6_no_residual_busy", busy, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
